// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants and types for the 8-bit accumulator CPU
//               control unit: opcodes, FSM states, accumulator source and
//               ALU operation encodings, and datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int PC_W       = 8;
  localparam int INSTR_W    = 8;
  localparam int REG_ADDR_W = 4;

  // Opcodes (IR[7:4])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_IMM  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ACC_SEL_IMM = 2'd0,
    ACC_SEL_REG = 2'd1,
    ACC_SEL_ALU = 2'd2
  } acc_sel_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/cu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cu_decoder
// Description : Combinational instruction decoder. Maps the instruction
//               register to datapath selects, write intents and control-flow
//               flags. Write intents are ungated; the FSM qualifies them.
// Ports       : ir          in  8  latched instruction
//               acc_sel     out 2  accumulator source select
//               alu_op      out 2  ALU operation
//               rf_we_int   out 1  instruction writes the register file
//               acc_we_int  out 1  instruction writes the accumulator
//               is_jmp/is_jz/is_halt/is_illegal  out 1  opcode class flags
// Revision    : 1.0 - initial release
// ============================================================================
module cu_decoder
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [1:0]         acc_sel,
  output logic [1:0]         alu_op,
  output logic               rf_we_int,
  output logic               acc_we_int,
  output logic               is_jmp,
  output logic               is_jz,
  output logic               is_halt,
  output logic               is_illegal
);

  logic [3:0] opcode;
  assign opcode = ir[7:4];

  always_comb begin
    acc_sel    = ACC_SEL_IMM;
    alu_op     = ALU_ADD;
    rf_we_int  = 1'b0;
    acc_we_int = 1'b0;
    is_jmp     = 1'b0;
    is_jz      = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP:  ;
      OP_ADD:  begin acc_sel = ACC_SEL_ALU; alu_op = ALU_ADD; acc_we_int = 1'b1; end
      OP_SUB:  begin acc_sel = ACC_SEL_ALU; alu_op = ALU_SUB; acc_we_int = 1'b1; end
      OP_AND:  begin acc_sel = ACC_SEL_ALU; alu_op = ALU_AND; acc_we_int = 1'b1; end
      OP_OR:   begin acc_sel = ACC_SEL_ALU; alu_op = ALU_OR;  acc_we_int = 1'b1; end
      OP_LD:   begin acc_sel = ACC_SEL_REG; acc_we_int = 1'b1; end
      OP_ST:   rf_we_int = 1'b1;
      OP_IMM:  begin acc_sel = ACC_SEL_IMM; acc_we_int = 1'b1; end
      OP_JMP:  is_jmp = 1'b1;
      OP_JZ:   is_jz = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;  // behaves as NOP otherwise
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_unit
// Description : Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
//               Three cycles per instruction; write strobes are asserted
//               only in EXECUTE; PC advances (or jumps) at the end of EXECUTE.
// Ports       : clk, rst (async, active-high), start
//               pc_address out 8 / instr_in in 8  - instruction memory
//               acc_value in 8, rf_rdata in 8      - datapath inputs (JZ/JMP)
//               rf_addr, rf_we, acc_we, acc_sel, alu_op, imm_value - datapath
//               halted, illegal_op (sticky)        - status
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter logic [7:0] PC_STEP  = 8'd2,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [PC_W-1:0]       pc_address,
  input  logic [INSTR_W-1:0]    instr_in,
  input  logic [7:0]            acc_value,
  input  logic [7:0]            rf_rdata,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic                  rf_we,
  output logic                  acc_we,
  output logic [1:0]            acc_sel,
  output logic [1:0]            alu_op,
  output logic [7:0]            imm_value,
  output logic                  halted,
  output logic                  illegal_op
);

  state_t            state, next_state;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_next;
  logic [INSTR_W-1:0] ir;
  logic              illegal_q;

  logic [1:0] dec_acc_sel;
  logic [1:0] dec_alu_op;
  logic       dec_rf_we;
  logic       dec_acc_we;
  logic       is_jmp;
  logic       is_jz;
  logic       is_halt;
  logic       is_illegal;

  cu_decoder u_decoder (
    .ir         (ir),
    .acc_sel    (dec_acc_sel),
    .alu_op     (dec_alu_op),
    .rf_we_int  (dec_rf_we),
    .acc_we_int (dec_acc_we),
    .is_jmp     (is_jmp),
    .is_jz      (is_jz),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // Jump target comes straight from the register file; odd targets are kept.
  always_comb begin
    if (is_jmp || (is_jz && (acc_value == 8'h00)))
      pc_next = rf_rdata;
    else
      pc_next = pc + PC_STEP;  // wraps modulo 256
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_FETCH)
        ir <= instr_in;
      if (state == ST_EXECUTE) begin
        pc <= pc_next;
        if (is_illegal)
          illegal_q <= 1'b1;
      end
    end
  end

  // Strobes decode directly from the state register, so an asynchronous
  // reset removes them in the same cycle.
  always_comb begin
    next_state = state;
    rf_we      = 1'b0;
    acc_we     = 1'b0;
    acc_sel    = ACC_SEL_IMM;
    alu_op     = ALU_ADD;
    halted     = 1'b0;
    case (state)
      ST_IDLE:    if (start) next_state = ST_FETCH;
      ST_FETCH:   next_state = ST_DECODE;
      ST_DECODE: begin
        acc_sel    = dec_acc_sel;
        alu_op     = dec_alu_op;
        next_state = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        acc_sel    = dec_acc_sel;
        alu_op     = dec_alu_op;
        rf_we      = dec_rf_we;
        acc_we     = dec_acc_we;
        next_state = is_halt ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (start) next_state = ST_FETCH;
      end
      default:    next_state = ST_IDLE;
    endcase
  end

  assign pc_address = pc;
  assign rf_addr    = ir[3:0];
  assign imm_value  = {4'h0, ir[3:0]};
  assign illegal_op = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control_unit
// Description : Directed self-checking bench for cpu_control_unit. Expected
//               per-instruction behaviour is queued as the program is loaded
//               and popped as each instruction runs. A second instance with
//               RESET_PC = 8'hFE covers PC wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start2;
  logic [7:0] pc_address, pc2;
  logic [7:0] instr_in;
  logic [7:0] acc_value, rf_rdata;
  logic [3:0] rf_addr, rf_addr2;
  logic       rf_we, acc_we, rf_we2, acc_we2;
  logic [1:0] acc_sel, alu_op, acc_sel2, alu_op2;
  logic [7:0] imm_value, imm2;
  logic       halted, illegal_op, halted2, illegal2;

  logic [7:0] mem [256];
  assign instr_in = mem[pc_address];

  always #5 clk = ~clk;

  cpu_control_unit #(.PC_STEP(8'd2), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pc_address(pc_address),
    .instr_in(instr_in), .acc_value(acc_value), .rf_rdata(rf_rdata),
    .rf_addr(rf_addr), .rf_we(rf_we), .acc_we(acc_we), .acc_sel(acc_sel),
    .alu_op(alu_op), .imm_value(imm_value), .halted(halted),
    .illegal_op(illegal_op)
  );

  cpu_control_unit #(.PC_STEP(8'd2), .RESET_PC(8'hFE)) u_wrap (
    .clk(clk), .rst(rst), .start(start2), .pc_address(pc2),
    .instr_in(8'h00), .acc_value(8'h00), .rf_rdata(8'h00),
    .rf_addr(rf_addr2), .rf_we(rf_we2), .acc_we(acc_we2), .acc_sel(acc_sel2),
    .alu_op(alu_op2), .imm_value(imm2), .halted(halted2),
    .illegal_op(illegal2)
  );

  typedef struct {
    logic [7:0] pc;
    logic [7:0] instr;
    logic [7:0] rdata;
    logic [7:0] accv;
    logic       acc_we;
    logic       rf_we;
    logic       chk_sel;
    logic [1:0] sel;
    logic [1:0] op;
    logic       chk_ill;
    logic       ill;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Load an instruction into memory and queue its expected behaviour.
  task automatic push(input logic [7:0] pc, input logic [7:0] instr,
                      input logic [7:0] rdata, input logic [7:0] accv,
                      input logic a_we, input logic r_we, input logic c_sel,
                      input logic [1:0] sel, input logic [1:0] op,
                      input logic c_ill, input logic ill);
    exp_t e;
    mem[pc] = instr;
    e.pc = pc; e.instr = instr; e.rdata = rdata; e.accv = accv;
    e.acc_we = a_we; e.rf_we = r_we; e.chk_sel = c_sel; e.sel = sel;
    e.op = op; e.chk_ill = c_ill; e.ill = ill;
    sb.push_back(e);
  endtask

  // Entered at the negedge of FETCH; leaves at the negedge after EXECUTE.
  task automatic run_instr(input exp_t e);
    rf_rdata  = e.rdata;
    acc_value = e.accv;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("pc@%0h.c%0d", e.pc, c), pc_address, e.pc);
      if (e.chk_ill)
        chk($sformatf("ill@%0h.c%0d", e.pc, c), {7'd0, illegal_op}, {7'd0, e.ill});
      if (c < 2) begin
        chk($sformatf("acc_we_early@%0h", e.pc), {7'd0, acc_we}, 8'd0);
        chk($sformatf("rf_we_early@%0h", e.pc), {7'd0, rf_we}, 8'd0);
      end else begin
        chk($sformatf("acc_we@%0h", e.pc), {7'd0, acc_we}, {7'd0, e.acc_we});
        chk($sformatf("rf_we@%0h", e.pc), {7'd0, rf_we}, {7'd0, e.rf_we});
        chk($sformatf("rf_addr@%0h", e.pc), {4'd0, rf_addr}, {4'd0, e.instr[3:0]});
        chk($sformatf("imm@%0h", e.pc), imm_value, {4'd0, e.instr[3:0]});
      end
      if (c > 0 && e.chk_sel) begin
        chk($sformatf("acc_sel@%0h.c%0d", e.pc, c), {6'd0, acc_sel}, {6'd0, e.sel});
        chk($sformatf("alu_op@%0h.c%0d", e.pc, c), {6'd0, alu_op}, {6'd0, e.op});
      end
      chk($sformatf("halted_run@%0h", e.pc), {7'd0, halted}, 8'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    acc_value = 8'h00; rf_rdata = 8'h00;

    // Reset state
    @(negedge clk);
    chk("rst_pc", pc_address, 8'h00);
    chk("rst_rf_we", {7'd0, rf_we}, 8'd0);
    chk("rst_acc_we", {7'd0, acc_we}, 8'd0);
    chk("rst_halted", {7'd0, halted}, 8'd0);
    chk("rst_illegal", {7'd0, illegal_op}, 8'd0);
    chk("rst_acc_sel", {6'd0, acc_sel}, 8'd0);
    chk("rst_alu_op", {6'd0, alu_op}, 8'd0);
    chk("rst_pc_wrap", pc2, 8'hFE);
    rst = 1'b0;

    // Wrap: NOP at FE advances to 00
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("wrap_hold.c%0d", c), pc2, 8'hFE);
      @(negedge clk);
    end
    chk("wrap_pc", pc2, 8'h00);
    chk("idle_pc", pc_address, 8'h00);

    // Program: pc, instr, rdata, accv, acc_we, rf_we, chk_sel, sel, op, chk_ill, ill
    push(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2'd0, 2'd0, 1, 0);
    push(8'h02, 8'hD3, 8'h00, 8'h00, 1, 0, 1, 2'd0, 2'd0, 1, 0);
    push(8'h04, 8'h50, 8'h00, 8'h03, 0, 1, 0, 2'd0, 2'd0, 1, 0);
    push(8'h06, 8'hD1, 8'h00, 8'h03, 1, 0, 1, 2'd0, 2'd0, 1, 0);
    push(8'h08, 8'h51, 8'h00, 8'h01, 0, 1, 0, 2'd0, 2'd0, 1, 0);
    push(8'h0A, 8'h10, 8'h00, 8'h01, 1, 0, 1, 2'd2, 2'd0, 1, 0);
    push(8'h0C, 8'hA2, 8'h20, 8'h00, 0, 0, 0, 2'd0, 2'd0, 1, 0);  // JZ taken
    push(8'h20, 8'hA2, 8'h20, 8'h05, 0, 0, 0, 2'd0, 2'd0, 1, 0);  // JZ not taken
    push(8'h22, 8'h6A, 8'h00, 8'h05, 0, 0, 0, 2'd0, 2'd0, 0, 0);  // illegal
    push(8'h24, 8'h23, 8'h00, 8'h05, 1, 0, 1, 2'd2, 2'd1, 1, 1);
    push(8'h26, 8'h33, 8'h00, 8'h05, 1, 0, 1, 2'd2, 2'd2, 1, 1);
    push(8'h28, 8'h90, 8'h40, 8'h05, 0, 0, 0, 2'd0, 2'd0, 1, 1);  // JMP 40
    push(8'h40, 8'h73, 8'h00, 8'h05, 1, 0, 1, 2'd2, 2'd3, 1, 1);
    push(8'h42, 8'h44, 8'h00, 8'h05, 1, 0, 1, 2'd1, 2'd0, 1, 1);
    push(8'h44, 8'hF0, 8'h00, 8'h05, 0, 0, 0, 2'd0, 2'd0, 1, 1);  // HALT
    mem[8'h46] = 8'h55;

    // Start pulse: next negedge is the first FETCH
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      run_instr(e);
    end

    // HALT: PC already advanced, no strobes
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("halt_flag.c%0d", c), {7'd0, halted}, 8'd1);
      chk($sformatf("halt_pc.c%0d", c), pc_address, 8'h46);
      chk($sformatf("halt_acc_we.c%0d", c), {7'd0, acc_we}, 8'd0);
      chk($sformatf("halt_rf_we.c%0d", c), {7'd0, rf_we}, 8'd0);
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("resume_halted", {7'd0, halted}, 8'd0);
    chk("resume_pc", pc_address, 8'h46);
    chk("resume_ill_sticky", {7'd0, illegal_op}, 8'd1);

    // ST R5 interrupted by reset during EXECUTE
    @(negedge clk);
    chk("st_decode_rf_we", {7'd0, rf_we}, 8'd0);
    @(negedge clk);
    chk("st_exec_rf_we", {7'd0, rf_we}, 8'd1);
    chk("st_exec_rf_addr", {4'd0, rf_addr}, 8'h05);
    rst = 1'b1;
    #1;
    chk("rst_async_rf_we", {7'd0, rf_we}, 8'd0);
    chk("rst_async_pc", pc_address, 8'h00);
    chk("rst_async_ill", {7'd0, illegal_op}, 8'd0);
    chk("rst_async_imm", imm_value, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle_pc.c%0d", c), pc_address, 8'h00);
      chk($sformatf("post_rst_rf_we.c%0d", c), {7'd0, rf_we}, 8'd0);
      chk($sformatf("post_rst_halted.c%0d", c), {7'd0, halted}, 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
